// File: rtl/multi_cycle_control_unit_if.sv
// Control bundle between the multi-cycle control unit and the RV32I datapath.
// master: the control unit; slave: the datapath that supplies opcode/status.
interface multi_cycle_control_unit_if;
   logic [6:0] part_of_inst;
   logic       alu_bcond;
   logic       halt_req;
   logic       pc_write;
   logic       ir_write;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;
   logic       mem_to_reg;
   logic       pc_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       is_ecall;
   logic       illegal_inst;
   logic       is_halted;
   logic [2:0] state;

   modport master (
      input  part_of_inst, alu_bcond, halt_req,
      output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
             pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, is_ecall, illegal_inst,
             is_halted, state
   );

   modport slave (
      output part_of_inst, alu_bcond, halt_req,
      input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
             pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, is_ecall, illegal_inst,
             is_halted, state
   );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB over a shared memory
// whose access latency is MEM_LAT cycles, with ECALL halt and illegal-opcode handling.
module multi_cycle_control_unit #(
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned CNT_W   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   multi_cycle_control_unit_if.master   bus
);

   localparam logic [6:0] OpArith    = 7'b0110011;
   localparam logic [6:0] OpArithImm = 7'b0010011;
   localparam logic [6:0] OpLoad     = 7'b0000011;
   localparam logic [6:0] OpStore    = 7'b0100011;
   localparam logic [6:0] OpBranch   = 7'b1100011;
   localparam logic [6:0] OpJal      = 7'b1101111;
   localparam logic [6:0] OpJalr     = 7'b1100111;
   localparam logic [6:0] OpEcall    = 7'b1110011;

   localparam logic [CNT_W-1:0] LatInit = CNT_W'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      StIf   = 3'd0,
      StId   = 3'd1,
      StEx   = 3'd2,
      StMem  = 3'd3,
      StWb   = 3'd4,
      StHalt = 3'd5
   } state_e;

   state_e           r_state;
   state_e           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_halted;
   logic             w_done;
   logic             w_known;
   logic [6:0]       w_op;

   assign w_op   = bus.part_of_inst;
   assign w_done = (r_cnt == '0);

   always_comb begin
      case (w_op)
         OpArith, OpArithImm, OpLoad, OpStore,
         OpBranch, OpJal, OpJalr, OpEcall: w_known = 1'b1;
         default:                          w_known = 1'b0;
      endcase
   end

   // Counter reloads on every state change, so IF and MEM each start a fresh access.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIf;
         r_cnt    <= LatInit;
         r_halted <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) begin
            r_cnt <= LatInit;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_next == StHalt) begin
            r_halted <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         StIf:   if (w_done) w_next = StId;
         StId: begin
            if (w_op == OpEcall)  w_next = bus.halt_req ? StHalt : StIf;
            else if (!w_known)    w_next = StIf;
            else                  w_next = StEx;
         end
         StEx: begin
            case (w_op)
               OpArith, OpArithImm: w_next = StWb;
               OpLoad, OpStore:     w_next = StMem;
               default:             w_next = StIf;
            endcase
         end
         StMem:  if (w_done) w_next = (w_op == OpLoad) ? StWb : StIf;
         StWb:   w_next = StIf;
         StHalt: w_next = StHalt;
         default: w_next = StIf;
      endcase
   end

   always_comb begin
      bus.pc_write     = 1'b0;
      bus.ir_write     = 1'b0;
      bus.i_or_d       = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.reg_write    = 1'b0;
      bus.mem_to_reg   = 1'b0;
      bus.pc_to_reg    = 1'b0;
      bus.alu_src_a    = 1'b0;
      bus.alu_src_b    = 2'b00;
      bus.alu_op       = 2'b00;
      bus.pc_source    = 2'b00;
      bus.is_ecall     = 1'b0;
      bus.illegal_inst = 1'b0;
      bus.is_halted    = 1'b0;
      bus.state        = 3'd0;
      if (!reset) begin
         bus.is_halted = r_halted;
         bus.state     = r_state;
         case (r_state)
            StIf: begin
               bus.mem_read = 1'b1;
               bus.ir_write = w_done;
            end
            StId: begin
               bus.alu_src_b = 2'b10;
               if (w_op == OpEcall) begin
                  bus.is_ecall = 1'b1;
                  bus.pc_write = !bus.halt_req;
               end else if (!w_known) begin
                  bus.illegal_inst = 1'b1;
                  bus.pc_write     = 1'b1;
               end
            end
            StEx: begin
               case (w_op)
                  OpArith: begin
                     bus.alu_src_a = 1'b1;
                     bus.alu_op    = 2'b10;
                  end
                  OpArithImm: begin
                     bus.alu_src_a = 1'b1;
                     bus.alu_src_b = 2'b10;
                     bus.alu_op    = 2'b10;
                  end
                  OpLoad, OpStore: begin
                     bus.alu_src_a = 1'b1;
                     bus.alu_src_b = 2'b10;
                  end
                  OpBranch: begin
                     bus.alu_src_a = 1'b1;
                     bus.alu_op    = 2'b01;
                     bus.pc_write  = 1'b1;
                     bus.pc_source = bus.alu_bcond ? 2'b10 : 2'b00;
                  end
                  OpJal: begin
                     bus.reg_write = 1'b1;
                     bus.pc_to_reg = 1'b1;
                     bus.pc_write  = 1'b1;
                     bus.pc_source = 2'b10;
                  end
                  OpJalr: begin
                     // A was latched in ID, so rd==rs1 cannot corrupt the target.
                     bus.alu_src_a = 1'b1;
                     bus.alu_src_b = 2'b10;
                     bus.reg_write = 1'b1;
                     bus.pc_to_reg = 1'b1;
                     bus.pc_write  = 1'b1;
                     bus.pc_source = 2'b01;
                  end
                  default: ;
               endcase
            end
            StMem: begin
               bus.i_or_d = 1'b1;
               if (w_op == OpLoad) begin
                  bus.mem_read = 1'b1;
               end else begin
                  bus.mem_write = 1'b1;
                  bus.pc_write  = w_done;
               end
            end
            StWb: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = (w_op == OpLoad);
               bus.pc_write   = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench: one control unit with MEM_LAT=1 and one with MEM_LAT=3, every
// cycle's full output vector compared against a hand-built expected vector.
module tb_multi_cycle_control_unit;

   localparam logic [6:0] OpArith    = 7'b0110011;
   localparam logic [6:0] OpArithImm = 7'b0010011;
   localparam logic [6:0] OpLoad     = 7'b0000011;
   localparam logic [6:0] OpStore    = 7'b0100011;
   localparam logic [6:0] OpBranch   = 7'b1100011;
   localparam logic [6:0] OpJal      = 7'b1101111;
   localparam logic [6:0] OpJalr     = 7'b1100111;
   localparam logic [6:0] OpEcall    = 7'b1110011;
   localparam logic [6:0] OpBad      = 7'b1111111;

   // Vector layout: pc_write,ir_write,i_or_d,mem_read,mem_write,reg_write,mem_to_reg,
   // pc_to_reg,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_source[1:0],is_ecall,illegal,halted,state
   localparam logic [20:0] PCW     = 21'h1 << 20;
   localparam logic [20:0] IRW     = 21'h1 << 19;
   localparam logic [20:0] IOD     = 21'h1 << 18;
   localparam logic [20:0] MRD     = 21'h1 << 17;
   localparam logic [20:0] MWR     = 21'h1 << 16;
   localparam logic [20:0] RGW     = 21'h1 << 15;
   localparam logic [20:0] M2R     = 21'h1 << 14;
   localparam logic [20:0] P2R     = 21'h1 << 13;
   localparam logic [20:0] ASA     = 21'h1 << 12;
   localparam logic [20:0] ASB_IMM = 21'h2 << 10;
   localparam logic [20:0] AOP_BR  = 21'h1 << 8;
   localparam logic [20:0] AOP_FN  = 21'h2 << 8;
   localparam logic [20:0] PCS_ALU = 21'h1 << 6;
   localparam logic [20:0] PCS_OUT = 21'h2 << 6;
   localparam logic [20:0] ECL     = 21'h1 << 5;
   localparam logic [20:0] ILL     = 21'h1 << 4;
   localparam logic [20:0] HLT     = 21'h1 << 3;
   localparam logic [20:0] S_IF    = 21'd0;
   localparam logic [20:0] S_ID    = 21'd1;
   localparam logic [20:0] S_EX    = 21'd2;
   localparam logic [20:0] S_MEM   = 21'd3;
   localparam logic [20:0] S_WB    = 21'd4;
   localparam logic [20:0] S_HALT  = 21'd5;

   logic clk = 1'b0;
   logic reset1;
   logic reset3;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   multi_cycle_control_unit_if if1 ();
   multi_cycle_control_unit_if if3 ();

   multi_cycle_control_unit #(.MEM_LAT(1), .CNT_W(4)) u_dut1 (
      .clk   (clk),
      .reset (reset1),
      .bus   (if1)
   );

   multi_cycle_control_unit #(.MEM_LAT(3), .CNT_W(4)) u_dut3 (
      .clk   (clk),
      .reset (reset3),
      .bus   (if3)
   );

   logic [20:0] v1;
   logic [20:0] v3;

   assign v1 = {if1.pc_write, if1.ir_write, if1.i_or_d, if1.mem_read, if1.mem_write,
                if1.reg_write, if1.mem_to_reg, if1.pc_to_reg, if1.alu_src_a, if1.alu_src_b,
                if1.alu_op, if1.pc_source, if1.is_ecall, if1.illegal_inst, if1.is_halted,
                if1.state};
   assign v3 = {if3.pc_write, if3.ir_write, if3.i_or_d, if3.mem_read, if3.mem_write,
                if3.reg_write, if3.mem_to_reg, if3.pc_to_reg, if3.alu_src_a, if3.alu_src_b,
                if3.alu_op, if3.pc_source, if3.is_ecall, if3.illegal_inst, if3.is_halted,
                if3.state};

   // Compare one full cycle at the falling edge, then return just after the next rising edge.
   task automatic chk(input bit sel3, input logic [20:0] exp, input string tag);
      logic [20:0] obs;
      @(negedge clk);
      obs = sel3 ? v3 : v1;
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset1 = 1'b1;
      reset3 = 1'b1;
      if1.part_of_inst = OpArith;
      if1.alu_bcond    = 1'b0;
      if1.halt_req     = 1'b0;
      if3.part_of_inst = OpLoad;
      if3.alu_bcond    = 1'b0;
      if3.halt_req     = 1'b0;

      chk(0, 21'd0, "reset_l1");
      chk(1, 21'd0, "reset_l3");
      reset1 = 1'b0;

      // MEM_LAT=1 arithmetic: 4 cycles
      chk(0, MRD | IRW | S_IF, "arith_if");
      chk(0, ASB_IMM | S_ID, "arith_id");
      chk(0, ASA | AOP_FN | S_EX, "arith_ex");
      chk(0, PCW | RGW | S_WB, "arith_wb");

      if1.part_of_inst = OpBranch;
      if1.alu_bcond    = 1'b1;
      chk(0, MRD | IRW | S_IF, "br1_if");
      chk(0, ASB_IMM | S_ID, "br1_id");
      chk(0, ASA | AOP_BR | PCW | PCS_OUT | S_EX, "br1_ex");
      if1.alu_bcond = 1'b0;
      chk(0, MRD | IRW | S_IF, "br0_if");
      chk(0, ASB_IMM | S_ID, "br0_id");
      chk(0, ASA | AOP_BR | PCW | S_EX, "br0_ex");

      if1.part_of_inst = OpJalr;
      chk(0, MRD | IRW | S_IF, "jalr_if");
      chk(0, ASB_IMM | S_ID, "jalr_id");
      chk(0, ASA | ASB_IMM | RGW | P2R | PCW | PCS_ALU | S_EX, "jalr_ex");
      if1.part_of_inst = OpJal;
      chk(0, MRD | IRW | S_IF, "jal_if");
      chk(0, ASB_IMM | S_ID, "jal_id");
      chk(0, RGW | P2R | PCW | PCS_OUT | S_EX, "jal_ex");

      if1.part_of_inst = OpStore;
      chk(0, MRD | IRW | S_IF, "st_if");
      chk(0, ASB_IMM | S_ID, "st_id");
      chk(0, ASA | ASB_IMM | S_EX, "st_ex");
      chk(0, IOD | MWR | PCW | S_MEM, "st_mem");

      if1.part_of_inst = OpArithImm;
      chk(0, MRD | IRW | S_IF, "imm_if");
      chk(0, ASB_IMM | S_ID, "imm_id");
      chk(0, ASA | ASB_IMM | AOP_FN | S_EX, "imm_ex");
      chk(0, PCW | RGW | S_WB, "imm_wb");

      if1.part_of_inst = OpEcall;
      chk(0, MRD | IRW | S_IF, "ecall_if");
      chk(0, ASB_IMM | ECL | PCW | S_ID, "ecall_id");

      if1.part_of_inst = OpBad;
      chk(0, MRD | IRW | S_IF, "ill_if");
      chk(0, ASB_IMM | ILL | PCW | S_ID, "ill_id");

      if1.part_of_inst = OpEcall;
      chk(0, MRD | IRW | S_IF, "halt_if");
      if1.halt_req = 1'b1;
      chk(0, ASB_IMM | ECL | S_ID, "halt_id");
      if1.halt_req = 1'b0;
      for (int i = 0; i < 20; i++) chk(0, HLT | S_HALT, "halt_hold");
      reset1 = 1'b1;
      chk(0, 21'd0, "halt_reset");
      reset1 = 1'b0;
      chk(0, MRD | IRW | S_IF, "post_halt_if");
      reset1 = 1'b1;

      // MEM_LAT=3 load: 9 cycles
      reset3 = 1'b0;
      chk(1, MRD | S_IF, "ld_if1");
      chk(1, MRD | S_IF, "ld_if2");
      chk(1, MRD | IRW | S_IF, "ld_if3");
      chk(1, ASB_IMM | S_ID, "ld_id");
      chk(1, ASA | ASB_IMM | S_EX, "ld_ex");
      chk(1, IOD | MRD | S_MEM, "ld_mem1");
      chk(1, IOD | MRD | S_MEM, "ld_mem2");
      chk(1, IOD | MRD | S_MEM, "ld_mem3");
      chk(1, PCW | RGW | M2R | S_WB, "ld_wb");

      // Store aborted by reset during MEM
      if3.part_of_inst = OpStore;
      chk(1, MRD | S_IF, "st3_if1");
      chk(1, MRD | S_IF, "st3_if2");
      chk(1, MRD | IRW | S_IF, "st3_if3");
      chk(1, ASB_IMM | S_ID, "st3_id");
      chk(1, ASA | ASB_IMM | S_EX, "st3_ex");
      chk(1, IOD | MWR | S_MEM, "st3_mem1");
      chk(1, IOD | MWR | S_MEM, "st3_mem2");
      reset3 = 1'b1;
      chk(1, 21'd0, "st3_reset");
      reset3 = 1'b0;
      chk(1, MRD | S_IF, "rst_if1");
      chk(1, MRD | S_IF, "rst_if2");
      chk(1, MRD | IRW | S_IF, "rst_if3");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Next-generation control unit for the multi-cycle RV32I core; replaces the single-cycle combinational decoder with a state machine that sequences IF/ID/EX/MEM/WB over a shared memory and ALU.
- Sits between the latched instruction register opcode field and the datapath muxes and enables.
- Parametrised memory latency, so the same FSM serves single-cycle and multi-cycle memories.
- Adds halt and illegal-opcode handling.

Parameters:
- MEM_LAT, 1, cycles each memory access state is held (legal range 1..15).
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  single core clock, rising edge.
- reset  in  1  synchronous, active-high.
- part_of_inst  in  7  opcode bits [6:0] of the latched IR; valid from ID onward.
- alu_bcond  in  1  branch-condition result from the ALU, valid in EX.
- halt_req  in  1  ECALL halt condition from the datapath (x17==10), valid in ID.
- pc_write  out  1  PC update enable.
- ir_write  out  1  IR and MDR capture enable for the fetch.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback select: MDR.
- pc_to_reg  out  1  writeback select: PC+4.
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = immediate.
- alu_op  out  2  ALU operation class: 00 add, 01 branch compare, 10 funct-decoded.
- pc_source  out  2  next-PC select: 00 = PC+4 adder, 01 = live ALU result, 10 = ALUOut.
- is_ecall  out  1  ECALL decoded, asserted in ID.
- illegal_inst  out  1  one-cycle pulse on an unknown opcode.
- is_halted  out  1  sticky halt flag.
- state  out  3  current state, for debug.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, on port reset.
- Opcodes: taken from the shared opcode defines.
  - ARITHMETIC 0110011, ARITHMETIC_IMM 0010011, LOAD 0000011, STORE 0100011.
  - BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- Reset:
  - State goes to IF, the counter loads MEM_LAT-1, and is_halted clears.
  - While reset is high, every output is forced to 0 (state reads 0).
  - Reset mid-instruction aborts the instruction; no writes occur.
- Output decode: all outputs except is_halted and state are combinational from the state, the opcode and alu_bcond. Any output not listed for a state is 0.
- Counter behaviour (IF, MEM):
  - On entry the counter loads MEM_LAT-1 and decrements each cycle.
  - The access completes in the cycle where the counter reads 0, so each access lasts MEM_LAT cycles.
  - mem_read or mem_write is held high for the whole access.
- IF: mem_read=1, i_or_d=0. On the completion cycle ir_write=1 and the FSM moves to ID.
- ID:
  - Sets alu_src_a=0, alu_src_b=10, alu_op=00 (ALUOut <= PC+imm).
  - ECALL: is_ecall=1. If halt_req is high, go to HALT with no PC write. Otherwise pc_write=1, pc_source=00, go to IF.
  - Unknown opcode: illegal_inst=1, pc_write=1, pc_source=00, go to IF (executes as NOP).
  - All other opcodes go to EX.
- EX:
  - ARITHMETIC: alu_src_a=1, alu_src_b=00, alu_op=10, then WB.
  - ARITHMETIC_IMM: same but alu_src_b=10, then WB.
  - LOAD / STORE: alu_src_a=1, alu_src_b=10, alu_op=00, then MEM.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write=1. pc_source=10 if alu_bcond else 00. Then IF.
  - JAL: reg_write=1, pc_to_reg=1, pc_write=1, pc_source=10, then IF.
  - JALR: alu_src_a=1, alu_src_b=10, alu_op=00, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=01, then IF. rd==rs1 is safe because A was latched in ID.
- MEM: i_or_d=1.
  - LOAD: mem_read=1. On completion go to WB; ir_write stays 0.
  - STORE: mem_write=1. On the completion cycle only, pc_write=1 and pc_source=00, then IF.
- WB: reg_write=1, mem_to_reg=1 for LOAD (else 0), pc_write=1, pc_source=00, then IF.
- HALT: absorbing. is_halted=1 (registered, set on entry) and all enables are 0. Only reset exits HALT.
- Cycles per instruction, with L = MEM_LAT:
  - R/I-type: L+3.
  - LOAD: 2L+3.
  - STORE: 2L+2.
  - BRANCH, JAL, JALR: L+2.
  - ECALL without halt: L+1.

Test Plan:
- MEM_LAT=1, ARITHMETIC opcode -> states 0,1,2,4,0; reg_write=1 only in WB; pc_write=1 exactly once, with pc_source=00; 4 cycles total.
- MEM_LAT=3, LOAD -> mem_read high for cycles 1-3 and 6-8; ir_write only on cycle 3; WB on cycle 9 with mem_to_reg=1 and reg_write=1; total 9 cycles.
- MEM_LAT=1, BRANCH with alu_bcond=1, then alu_bcond=0 -> EX shows pc_write=1 with pc_source=10, then 00; 3 cycles each; reg_write never asserted.
- JALR, then JAL -> EX shows reg_write=pc_to_reg=pc_write=1; pc_source=01 for JALR and 10 for JAL; STORE shows mem_write=1 with reg_write=0 throughout.
- ECALL with halt_req=0 -> is_ecall=1 in ID, return to IF. ECALL with halt_req=1 -> state=5, is_halted=1 held 20 cycles with no enables; reset clears to state 0.
- Opcode 1111111 -> illegal_inst pulses 1 cycle in ID with pc_write=1 and pc_source=00. Reset asserted mid-MEM of a STORE (MEM_LAT=3) -> mem_write drops the same cycle, no pc_write, and the FSM restarts at IF.
